// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_arbiter
//  Brief    : Round-robin arbiter sharing one register-file read port among
//             NUM_REQ requesters, with a one-cycle registered response.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic                      stall,
    output logic [ADDR_W-1:0]         read,
    input  logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int                c_PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                c_SUM_W   = c_PTR_W + 1;
    localparam logic [c_SUM_W-1:0] c_NUM_EXT = c_SUM_W'(NUM_REQ);
    localparam logic [c_SUM_W-1:0] c_ONE     = c_SUM_W'(1);

    logic [c_PTR_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;

    logic               w_found;
    logic [c_PTR_W-1:0] w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ADDR_W-1:0]  w_read;

    // Index base+off folded back into 0..NUM_REQ-1; off never exceeds NUM_REQ.
    function automatic logic [c_PTR_W-1:0] f_wrap_add(
        input logic [c_PTR_W-1:0] base,
        input logic [c_SUM_W-1:0] off
    );
        logic [c_SUM_W-1:0] s;
        s = {1'b0, base} + off;
        if (s >= c_NUM_EXT) begin
            s = s - c_NUM_EXT;
        end
        return s[c_PTR_W-1:0];
    endfunction

    // Scan from rr_ptr upward; the first pending requester wins.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        if (!reset && !stall) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req[f_wrap_add(rr_ptr_q, c_SUM_W'(i))]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = f_wrap_add(rr_ptr_q, c_SUM_W'(i));
                end
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_found) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    // Idle cycles keep presenting the previous address so the mux stays quiet.
    always_comb begin
        w_read = last_addr_q;
        if (reset) begin
            w_read = '0;
        end else if (w_found) begin
            w_read = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        rsp_valid_d = w_gnt;
        rsp_data_d  = rsp_data_q;
        last_addr_d = last_addr_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_found) begin
            rsp_data_d  = rd_data;
            last_addr_d = w_read;
            rr_ptr_d    = f_wrap_add(w_gnt_idx, c_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            last_addr_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            last_addr_q <= last_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt       = w_gnt;
    assign read      = w_read;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire
